// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the iterative divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_WIDTH_DEFAULT = 8;

   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   assign shifted  = {rem, bit_in};
   assign trial    = shifted - {1'b0, divisor};
   assign q_bit    = ~trial[WIDTH];
   assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/iter_div.sv
// Radix-2 restoring divider with start/done handshake.
// Define SIGNED_DIV_EN to add the is_signed port and signed division.
module iter_div
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
`ifdef SIGNED_DIV_EN
   ,
   input  logic             is_signed
`endif
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   div_state_t state, state_next;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] prem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic             q_neg;
   logic             r_neg;

   logic             sgn;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             accept;
   logic             zero;
   logic [WIDTH-1:0] rem_next;
   logic             q_bit;
   logic [WIDTH-1:0] q_raw;

`ifdef SIGNED_DIV_EN
   assign sgn = is_signed;
`else
   assign sgn = 1'b0;
`endif

   assign a_neg  = sgn & dividend[WIDTH-1];
   assign b_neg  = sgn & divisor[WIDTH-1];
   assign a_mag  = a_neg ? -dividend : dividend;
   assign b_mag  = b_neg ? -divisor : divisor;
   assign accept = start && (state != RUN);
   assign zero   = (divisor == '0);
   assign q_raw  = {dvd[WIDTH-2:0], q_bit};

   assign busy = (state == RUN);
   assign done = (state == DONE);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (prem),
      .bit_in   (dvd[WIDTH-1]),
      .divisor  (dvs),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, DONE: begin
            if (start) state_next = zero ? DONE : RUN;
            else       state_next = IDLE;
         end
         RUN: begin
            if (cnt == LAST) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         prem        <= '0;
         dvd         <= '0;
         dvs         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         cnt   <= '0;
         prem  <= '0;
         dvd   <= a_mag;
         dvs   <= b_mag;
         q_neg <= a_neg ^ b_neg;
         r_neg <= a_neg;
         if (zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            div_by_zero <= 1'b0;
         end
      end else if (state == RUN) begin
         cnt  <= cnt + 1'b1;
         prem <= rem_next;
         dvd  <= q_raw;
         // Sign fix-up folds into the last step so latency is unchanged
         if (cnt == LAST) begin
            quotient  <= q_neg ? -q_raw : q_raw;
            remainder <= r_neg ? -rem_next : rem_next;
         end
      end
   end

endmodule

// File: tb/tb_iter_div.sv
// Directed self-checking bench for iter_div at WIDTH=8.
module tb_iter_div;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;
`ifdef SIGNED_DIV_EN
   logic       is_signed;
`endif

   int checks = 0;
   int errors = 0;

   iter_div #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
`ifdef SIGNED_DIV_EN
      ,
      .is_signed   (is_signed)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Counts edges until done, plus cycles observed with busy high.
   task automatic wait_done(output int n, output int bc);
      n  = 0;
      bc = 0;
      while (!done && n < 40) begin
         if (busy) bc++;
         @(posedge clk);
         #1;
         n++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eq,
                         input logic [7:0] er, input logic ez,
                         input int elat, input int ebusy);
      int n, bc;
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(n, bc);
      check({tag, "_q"}, {24'd0, quotient}, {24'd0, eq});
      check({tag, "_r"}, {24'd0, remainder}, {24'd0, er});
      check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
      check({tag, "_lat"}, n + 1, elat);
      check({tag, "_busycyc"}, bc, ebusy);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_q_hold"}, {24'd0, quotient}, {24'd0, eq});
   endtask

   initial begin
      int n, bc, seen;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
`ifdef SIGNED_DIV_EN
      is_signed = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_q", {24'd0, quotient}, 32'd0);
      check("rst_r", {24'd0, remainder}, 32'd0);
      check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("u200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, 8);
      run_op("u5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1, 0);
      run_op("u13_13", 8'd13, 8'd13, 8'd1, 8'd0, 1'b0, 9, 8);

      // Back-to-back: start held across the first done
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd3;
      divisor  = 8'd9;
      @(posedge clk);
      #1;
      dividend = 8'd255;
      divisor  = 8'd1;
      wait_done(n, bc);
      check("b2b1_q", {24'd0, quotient}, 32'd0);
      check("b2b1_r", {24'd0, remainder}, 32'd3);
      check("b2b1_lat", n + 1, 9);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b2_accept", {31'd0, busy}, 32'd1);
      wait_done(n, bc);
      check("b2b2_q", {24'd0, quotient}, 32'd255);
      check("b2b2_r", {24'd0, remainder}, 32'd0);
      check("b2b2_lat", n + 1, 9);
      @(posedge clk);
      #1;

      // start while busy is ignored
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd10;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd50;
      divisor  = 8'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("ign_busy", {31'd0, busy}, 32'd1);
      wait_done(n, bc);
      check("ign_lat", n, 4);
      check("ign_q", {24'd0, quotient}, 32'd10);
      check("ign_r", {24'd0, remainder}, 32'd0);
      @(posedge clk);
      #1;

      // Reset mid-operation
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd77;
      divisor  = 8'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_q", {24'd0, quotient}, 32'd0);
      check("abort_r", {24'd0, remainder}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check("abort_no_done", seen, 0);
      run_op("u9_4", 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 9, 8);

`ifdef SIGNED_DIV_EN
      is_signed = 1'b1;
      run_op("s-7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 9, 8);
      run_op("s-128_-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9, 8);
      run_op("s7_-2", 8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, 9, 8);
      run_op("s-5_0", 8'hFB, 8'd0, 8'hFF, 8'hFB, 1'b1, 1, 0);
      is_signed = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
